// File: rtl/gfx_dot_pkg.sv
// Shared constants and helpers for the planar dot serializer.
// pix_at gathers one pixel index across bitplanes of a zero-padded pattern word.
package gfx_dot_pkg;

    localparam int MAX_BPP   = 8;
    localparam int MAX_PPW   = 32;
    localparam int MAX_W     = MAX_BPP * MAX_PPW;

    localparam int DEF_BPP   = 4;
    localparam int DEF_PPW   = 8;
    localparam int DEF_LANES = 2;
    localparam int STEPS     = DEF_PPW / DEF_LANES;

    function automatic int calc_steps(input int ppw, input int lanes);
        return ppw / lanes;
    endfunction

    function automatic int phw(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic logic [MAX_BPP-1:0] pix_at(input logic [MAX_W-1:0] word,
                                                  input int idx,
                                                  input int bpp,
                                                  input int ppw);
        logic [MAX_W-1:0] sh;
        pix_at = '0;
        for (int p = 0; p < MAX_BPP; p++) begin
            if (p < bpp) begin
                sh = word >> (p * ppw + idx);
                pix_at[p] = sh[0];
            end
        end
    endfunction

endpackage

// File: rtl/gfx_dot_fifo.sv
// Synchronous prefetch FIFO for pattern words; count-based full/empty, no read pass-through.
module gfx_dot_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gfx_dot_serializer.sv
// Planar pattern word to per-CE lane pixel serializer with flip, lane rotation and prefetch FIFO.
// The shift register either holds a live word or is empty; an empty SR takes its word straight from the FIFO head.
module gfx_dot_serializer
    import gfx_dot_pkg::*;
#(
    parameter int BPP   = DEF_BPP,
    parameter int PPW   = DEF_PPW,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = 2
) (
    input  logic                    clk_12m,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    flush,
    input  logic [BPP*PPW-1:0]      cr,
    input  logic                    cr_h,
    input  logic                    cr_valid,
    output logic                    cr_ready,
    input  logic [phw(LANES)-1:0]   phase,
    output logic [LANES*BPP-1:0]    gd,
    output logic [LANES-1:0]        dot,
    output logic                    pix_valid,
    output logic                    underrun
);

    localparam int W       = BPP * PPW;
    localparam int N_STEPS = calc_steps(PPW, LANES);
    localparam int SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int OW      = LANES * BPP;

    logic [W-1:0]     sr;
    logic             sr_h;
    logic             sr_valid;
    logic [SW-1:0]    step;

    logic [W:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [W-1:0]     src_word;
    logic             src_h;
    logic [SW-1:0]    src_step;
    logic             last;
    logic             emit;

    logic [OW-1:0]    lanes_pix;
    logic [LANES-1:0] lanes_dot;

    assign cr_ready = !reset && !flush && !fifo_full;
    assign push     = cr_valid && cr_ready;

    // An empty SR sources step 0 of the FIFO head so a refill costs no extra CE.
    assign src_word = sr_valid ? sr   : fifo_rdata[W-1:0];
    assign src_h    = sr_valid ? sr_h : fifo_rdata[W];
    assign src_step = sr_valid ? step : '0;
    assign last     = (src_step == SW'(N_STEPS - 1));
    assign emit     = ce && (sr_valid || !fifo_empty);
    assign pop      = !reset && !flush && ce && !fifo_empty && (!sr_valid || last);

    gfx_dot_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_12m),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({cr_h, cr}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        logic [MAX_W-1:0]   word_pad;
        logic [MAX_BPP-1:0] px;
        int                 slot;
        int                 idx;
        lanes_pix = '0;
        lanes_dot = '0;
        word_pad  = '0;
        word_pad[W-1:0] = src_word;
        px   = '0;
        slot = 0;
        idx  = 0;
        for (int l = 0; l < LANES; l++) begin
            slot = (l + int'(phase)) % LANES;
            idx  = int'(src_step) * LANES + slot;
            if (src_h) idx = PPW - 1 - idx;
            px = pix_at(word_pad, idx, BPP, PPW);
            lanes_pix[l*BPP +: BPP] = px[BPP-1:0];
            lanes_dot[l] = |px;
        end
    end

    always_ff @(posedge clk_12m) begin
        if (reset) begin
            sr        <= '0;
            sr_h      <= 1'b0;
            sr_valid  <= 1'b0;
            step      <= '0;
            gd        <= '0;
            dot       <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush) begin
            sr_valid  <= 1'b0;
            step      <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (ce) begin
            if (emit) begin
                gd        <= lanes_pix;
                dot       <= lanes_dot;
                pix_valid <= 1'b1;
                if (!last) begin
                    sr       <= src_word;
                    sr_h     <= src_h;
                    step     <= src_step + SW'(1);
                    sr_valid <= 1'b1;
                end else if (sr_valid && !fifo_empty) begin
                    sr       <= fifo_rdata[W-1:0];
                    sr_h     <= fifo_rdata[W];
                    step     <= '0;
                    sr_valid <= 1'b1;
                end else begin
                    sr_valid <= 1'b0;
                    step     <= '0;
                end
            end else begin
                gd        <= '0;
                dot       <= '0;
                pix_valid <= 1'b0;
                underrun  <= 1'b1;
            end
        end else begin
            pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gfx_dot_serializer.sv
// Bench for gfx_dot_serializer: pattern table, hand-written corner sequences and a random run
// against a queue-based pixel-stream reference model.
module tb_gfx_dot_serializer;

    localparam int BPP   = 4;
    localparam int PPW   = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce;
    logic                 flush;
    logic [BPP*PPW-1:0]   cr;
    logic                 cr_h;
    logic                 cr_valid;
    logic                 cr_ready;
    logic [0:0]           phase;
    logic [LANES*BPP-1:0] gd;
    logic [LANES-1:0]     dot;
    logic                 pix_valid;
    logic                 underrun;

    gfx_dot_serializer #(
        .BPP   (BPP),
        .PPW   (PPW),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk_12m   (clk),
        .reset     (reset),
        .ce        (ce),
        .flush     (flush),
        .cr        (cr),
        .cr_h      (cr_h),
        .cr_valid  (cr_valid),
        .cr_ready  (cr_ready),
        .phase     (phase),
        .gd        (gd),
        .dot       (dot),
        .pix_valid (pix_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [32:0]          q[$];
    logic [31:0]          cur_w;
    logic                 cur_h;
    logic                 cur_on;
    int                   cur_pos;
    logic [LANES*BPP-1:0] exp_gd;
    logic [LANES-1:0]     exp_dot;
    logic                 exp_pv;
    logic                 exp_un;
    logic                 ready_seen;

    typedef struct {
        logic [31:0] word;
        logic        h;
        logic        ph;
        logic [31:0] gd4;   // {step3, step2, step1, step0}
        logic [7:0]  dot4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int pix(input logic [31:0] w, input int i);
        int r = 0;
        for (int p = 0; p < BPP; p++)
            r += int'((w >> (p * PPW + i)) & 32'd1) << p;
        return r;
    endfunction

    task automatic model_update(input logic acc);
        logic [32:0] e;
        bit popped;
        int slot, i, p;
        popped = 0;
        if (reset) begin
            q.delete();
            cur_on = 0; exp_gd = '0; exp_dot = '0; exp_pv = 0; exp_un = 0;
        end else if (flush) begin
            q.delete();
            cur_on = 0; exp_pv = 0; exp_un = 0;
        end else begin
            if (ce) begin
                if (!cur_on && q.size() > 0) begin
                    e = q.pop_front();
                    cur_w = e[31:0]; cur_h = e[32]; cur_pos = 0; cur_on = 1; popped = 1;
                end
                if (cur_on) begin
                    for (int l = 0; l < LANES; l++) begin
                        slot = (l + int'(phase)) % LANES;
                        i = cur_pos + slot;
                        if (cur_h) i = PPW - 1 - i;
                        p = pix(cur_w, i);
                        exp_gd[l*BPP +: BPP] = BPP'(p);
                        exp_dot[l] = (p != 0);
                    end
                    exp_pv = 1;
                    cur_pos += LANES;
                    if (cur_pos >= PPW) begin
                        cur_on = 0;
                        if (!popped && q.size() > 0) begin
                            e = q.pop_front();
                            cur_w = e[31:0]; cur_h = e[32]; cur_pos = 0; cur_on = 1;
                        end
                    end
                end else begin
                    exp_gd = '0; exp_dot = '0; exp_pv = 0; exp_un = 1;
                end
            end else begin
                exp_pv = 0;
            end
            if (acc) q.push_back({cr_h, cr});
        end
    endtask

    task automatic cyc();
        logic exp_ready;
        @(negedge clk);
        exp_ready  = !reset && !flush && (q.size() < DEPTH);
        ready_seen = cr_ready;
        check("cr_ready", cr_ready, exp_ready);
        model_update(cr_valid && exp_ready);
        @(posedge clk);
        #1;
        check("gd", gd, exp_gd);
        check("dot", dot, exp_dot);
        check("pix_valid", pix_valid, exp_pv);
        check("underrun", underrun, exp_un);
    endtask

    task automatic idle_inputs();
        reset = 0; ce = 0; flush = 0; cr_valid = 0; cr = '0; cr_h = 0; phase = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    vec_t vecs[5];
    int   cnt;

    initial begin
        vecs[0] = '{32'h0000_00AA, 1'b0, 1'b0, 32'h1010_1010, 8'hAA};
        vecs[1] = '{32'h0000_00AA, 1'b1, 1'b0, 32'h0101_0101, 8'h55};
        vecs[2] = '{32'h0000_00AA, 1'b0, 1'b1, 32'h0101_0101, 8'h55};
        vecs[3] = '{32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 8'h80};
        vecs[4] = '{32'hF000_000F, 1'b1, 1'b1, 32'h1111_8888, 8'hFF};

        q.delete();
        cur_on = 0; cur_pos = 0; cur_w = '0; cur_h = 0;
        exp_gd = '0; exp_dot = '0; exp_pv = 0; exp_un = 0;

        // reset state
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        check("rst_ready", ready_seen, 1'b0);
        reset = 0;

        // pattern table: one word, four CEs
        foreach (vecs[v]) begin
            do_reset();
            cr = vecs[v].word; cr_h = vecs[v].h; phase = vecs[v].ph; cr_valid = 1;
            cyc();
            cr_valid = 0; ce = 1;
            for (int s = 0; s < 4; s++) begin
                cyc();
                check($sformatf("vec%0d_gd_s%0d", v, s), gd, vecs[v].gd4[s*8 +: 8]);
                check($sformatf("vec%0d_dot_s%0d", v, s), dot, vecs[v].dot4[s*2 +: 2]);
                check($sformatf("vec%0d_pv_s%0d", v, s), pix_valid, 1'b1);
            end
            ce = 0;
        end

        // three back-to-back words, third waits on a full FIFO
        do_reset();
        cr_valid = 1; cr = 32'h1111_1111; cyc();
        cr = 32'h2222_2222; cyc();
        cr = 32'h3333_3333; cyc();
        check("b2b_full_ready", ready_seen, 1'b0);
        ce = 1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cr_valid = (i < 2);
            cyc();
            if (i == 0) check("b2b_ready_popcycle", ready_seen, 1'b0);
            if (i == 1) check("b2b_ready_freed", ready_seen, 1'b1);
            if (pix_valid === 1'b1) cnt++;
        end
        check("b2b_pv_count", cnt, 12);
        cr_valid = 0;
        cyc();
        check("b2b_underrun_pv", pix_valid, 1'b0);
        check("b2b_underrun_gd", gd, 8'h00);
        check("b2b_underrun", underrun, 1'b1);
        ce = 0; cyc(); cyc();
        check("underrun_sticky", underrun, 1'b1);
        flush = 1; cyc(); flush = 0;
        check("flush_clears_underrun", underrun, 1'b0);

        // flush at step 2 with a word queued and an offer pending
        do_reset();
        cr_valid = 1; cr = 32'h5555_5555; cyc();
        cr = 32'h6666_6666; cyc();
        cr_valid = 0; ce = 1; cyc(); cyc();
        flush = 1; cr_valid = 1; cr = 32'h7777_7777; cyc();
        check("flush_ready", ready_seen, 1'b0);
        check("flush_pv", pix_valid, 1'b0);
        flush = 0; cr_valid = 0; cyc();
        check("post_flush_pv", pix_valid, 1'b0);
        check("post_flush_empty", underrun, 1'b1);
        ce = 0;

        // reset mid-word
        do_reset();
        cr_valid = 1; cr = 32'hFFFF_FFFF; cyc();
        cr_valid = 0; ce = 1; cyc(); cyc();
        reset = 1; cyc();
        check("midrst_gd", gd, 8'h00);
        check("midrst_dot", dot, 2'b00);
        check("midrst_pv", pix_valid, 1'b0);
        check("midrst_ready", ready_seen, 1'b0);
        reset = 0; ce = 0;

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ce       = ($urandom_range(0, 9) < 7);
            cr_valid = $urandom_range(0, 1);
            cr       = $urandom;
            cr_h     = $urandom_range(0, 1);
            phase    = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 49) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            cyc();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
